target_spi: RTL and testbench
=============================

// Module: target_spi
// PURPOSE
//  SPI mode-0 target (slave) that terminates frames issued by the host-side SPI master.
//  Decodes each DW-bit frame into a register read or write on a simple local register port.
//  On reads, returns RX bits of read data in the tail of the same frame.
//  Oversampling design: SCK/CSN/MOSI are asynchronous inputs, synchronized into clk.
// PARAMETERS
//  DW   38  total frame length in SCK cycles
//  TX   22  command field width: {rw(1), addr(TX-RX-1), wdata(RX)}; MSB first
//  RX   16  data width; also the width of the read-data tail returned on MISO
//  AW   5   address width; must equal TX-RX-1
// PORTS
//  clk           in   1   system clock; frequency >= 8x SCK frequency
//  rst_n         in   1   asynchronous reset, active low
//  spi_sck       in   1   SPI clock, idle low (mode 0)
//  spi_csn       in   1   chip select, active low
//  spi_mosi      in   1   host->target data, valid on SCK rise
//  spi_miso      out  1   target->host data, changes after SCK fall
//  spi_miso_oe   out  1   MISO output enable; high only while CSN is synchronized-low
//  reg_addr      out  AW  register address
//  reg_wdata     out  RX  write data
//  reg_we        out  1   one-clk write strobe
//  reg_re        out  1   one-clk read strobe
//  reg_rdata     in   RX  read data, sampled exactly 1 clk after reg_re
//  frame_err     out  1   one-clk pulse: CSN deasserted with bit count != DW
// BEHAVIOUR
//  Reset: spi_miso=0, spi_miso_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_err=0;
//   bit_cnt=0, shift regs=0, state=IDLE. All SPI inputs use 2-FF synchronizers and a third
//   register stage for edge detection; sync flops reset to sck=0, csn=1, mosi=0.
//  States: IDLE -> CMD (CSN fall) -> DATA (after TX-th rise) -> IDLE (CSN rise).
//  IDLE: bit_cnt cleared; MISO held 0. CSN fall -> CMD; spi_miso_oe=1.
//  CMD: each SCK rise shifts MOSI into cmd_sr (MSB first), bit_cnt++.
//   On the TX-th rise: latch rw, addr, wdata into reg_addr/reg_wdata; go DATA.
//   If rw=0 (read): assert reg_re for 1 clk on that same cycle; capture reg_rdata next clk
//   into miso_sr. If rw=1 (write): miso_sr loaded per CONFIGURATION.
//  DATA: on each SCK fall, spi_miso <= miso_sr[RX-1], miso_sr shifts left; first
//   fall after entering DATA drives read-data MSB. SCK rises keep counting bit_cnt (saturates at 63).
//  CSN rise (any state): spi_miso_oe=0, spi_miso=0, state=IDLE.
//   If bit_cnt==DW and rw=1: pulse reg_we 1 clk with latched addr/wdata.
//   If bit_cnt!=DW: no reg_we, pulse frame_err 1 clk (read side effect already issued is kept).
//   CSN rise with bit_cnt==0 (glitch frame): no strobes, no frame_err.
//  SCK edges while CSN high are ignored. SCK rise and CSN rise in same synchronized clk:
//   the rise is counted first, then the end-of-frame rules apply.
//  Back-to-back frames: CSN fall within 2 clk of prior rise is accepted; prior reg_we still issued.
//  reg_we and reg_re are never asserted in the same clk.
//  Async reset mid-frame: all state cleared immediately; rest of that frame ignored until
//   next CSN fall.
// CONFIGURATION
//  TARGET_SPI_STATUS_EN defined: on write frames the MISO tail returns
//   {8'hA5, frame_cnt[7:0]}, frame_cnt = count of completed (bit_cnt==DW) frames since
//   reset, wrapping 255->0; increments on CSN rise.
//  Not defined: write-frame MISO tail is all zeros; no frame counter logic.
// TESTING
//  1 write: frame {1'b1,5'h0A,16'hBEEF} -> one reg_we, reg_addr=0x0A, reg_wdata=0xBEEF; host rx=0x0000 (STATUS off).
//  2 read: {1'b0,5'h03,16'h0000}, reg_rdata=0x1234 -> one reg_re addr 0x03, host rx_data=0x1234.
//  3 abort: CSN raised after 30 SCK on write -> no reg_we, frame_err pulse once, next frame OK.
//  4 back-to-back: write 0x5555@0x01 then read @0x01 (reg model) -> host rx=0x5555.
//  5 reset mid-frame: rst_n low after 10 bits -> outputs at reset values; next full read correct.
//  6 STATUS_EN: three writes -> host rx values 0xA500, 0xA501, 0xA502.

Source files
------------

// File: rtl/target_spi.sv
// rtl/target_spi.sv - SPI mode-0 target decoding DW-bit frames into local register reads/writes
// Optional feature macro: TARGET_SPI_STATUS_EN (write-frame MISO tail = {8'hA5, frame_cnt}).
module target_spi #(
    parameter int DW = 38,
    parameter int TX = 22,
    parameter int RX = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_sck,
    input  logic          spi_csn,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    output logic [AW-1:0] reg_addr,
    output logic [RX-1:0] reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [RX-1:0] reg_rdata,
    output logic          frame_err
);
    localparam logic [5:0] CNT_CMD_LAST = 6'(TX - 1);
    localparam logic [5:0] CNT_FULL     = 6'(DW);

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sck_sync_q, sck_sync_d;
    logic [2:0]    csn_sync_q, csn_sync_d;
    logic [1:0]    mosi_sync_q, mosi_sync_d;
    logic [1:0]    settle_q, settle_d;
    logic          armed_q, armed_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [TX-2:0] cmd_sr_q, cmd_sr_d;
    logic [RX-1:0] miso_sr_q, miso_sr_d;
    logic          rw_q, rw_d;
    logic          rd_pend_q, rd_pend_d;
    logic          spi_miso_q, spi_miso_d;
    logic          miso_oe_q, miso_oe_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [RX-1:0] reg_wdata_q, reg_wdata_d;
    logic          reg_we_q, reg_we_d;
    logic          reg_re_q, reg_re_d;
    logic          frame_err_q, frame_err_d;
    logic [RX-1:0] write_tail;
    logic [TX-1:0] cmd_new;
    logic [5:0]    cnt_inc;
    logic          sck_rise, sck_fall, csn_rise, csn_fall;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
    assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
    assign cmd_new  = {cmd_sr_q, mosi_sync_q[1]};
    assign cnt_inc  = (bit_cnt_q == 6'd63) ? bit_cnt_q : bit_cnt_q + 6'd1;

`ifdef TARGET_SPI_STATUS_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    assign write_tail = RX'({8'hA5, frame_cnt_q});
`else
    assign write_tail = '0;
`endif

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[1:0], spi_sck};
        csn_sync_d  = {csn_sync_q[1:0], spi_csn};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        settle_d    = settle_q[1] ? settle_q : settle_q + 2'd1;
        // A CSN already low when reset releases must not look like a new frame start.
        armed_d     = armed_q | (settle_q[1] & csn_sync_q[1]);
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        miso_sr_d   = miso_sr_q;
        rw_d        = rw_q;
        rd_pend_d   = reg_re_q;
        spi_miso_d  = spi_miso_q;
        miso_oe_d   = miso_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        frame_err_d = 1'b0;
`ifdef TARGET_SPI_STATUS_EN
        frame_cnt_d = frame_cnt_q;
`endif

        if (rd_pend_q) begin
            miso_sr_d = reg_rdata;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                spi_miso_d = 1'b0;
                if (csn_fall && armed_q) begin
                    state_d   = CMD;
                    miso_oe_d = 1'b1;
                    cmd_sr_d  = '0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    cmd_sr_d  = cmd_new[TX-2:0];
                    bit_cnt_d = cnt_inc;
                    if (bit_cnt_q == CNT_CMD_LAST) begin
                        state_d     = DATA;
                        rw_d        = cmd_new[TX-1];
                        reg_addr_d  = cmd_new[TX-2 -: AW];
                        reg_wdata_d = cmd_new[RX-1:0];
                        if (cmd_new[TX-1]) begin
                            miso_sr_d = write_tail;
                        end else begin
                            reg_re_d = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (sck_rise) begin
                    bit_cnt_d = cnt_inc;
                end
                if (sck_fall) begin
                    spi_miso_d = miso_sr_q[RX-1];
                    miso_sr_d  = {miso_sr_q[RX-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        // End of frame is judged on the count after any coincident SCK rise.
        if (csn_rise) begin
            state_d    = IDLE;
            miso_oe_d  = 1'b0;
            spi_miso_d = 1'b0;
            if (bit_cnt_d == CNT_FULL) begin
                reg_we_d = (state_q == DATA) && rw_q;
`ifdef TARGET_SPI_STATUS_EN
                frame_cnt_d = frame_cnt_q + 8'd1;
`endif
            end else if (bit_cnt_d != 6'd0) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sck_sync_q  <= 3'b000;
            csn_sync_q  <= 3'b111;
            mosi_sync_q <= 2'b00;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            miso_sr_q   <= '0;
            rw_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            spi_miso_q  <= 1'b0;
            miso_oe_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef TARGET_SPI_STATUS_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            miso_sr_q   <= miso_sr_d;
            rw_q        <= rw_d;
            rd_pend_q   <= rd_pend_d;
            spi_miso_q  <= spi_miso_d;
            miso_oe_q   <= miso_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            frame_err_q <= frame_err_d;
`ifdef TARGET_SPI_STATUS_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign spi_miso    = spi_miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_we      = reg_we_q;
    assign reg_re      = reg_re_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_target_spi.sv
// tb/tb_target_spi.sv - table-driven and randomized checks of target_spi against a frame-level model
module tb_target_spi;
    localparam int DW   = 38;
    localparam int TX   = 22;
    localparam int RX   = 16;
    localparam int HALF = 5;
`ifdef TARGET_SPI_STATUS_EN
    localparam bit STATUS_ON = 1'b1;
`else
    localparam bit STATUS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata = 16'h0000;
    logic        frame_err;

    target_spi dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int fc_model = 0;
    logic [4:0]  mon_addr = 5'h00;
    logic [15:0] mon_wdata = 16'h0000;
    logic [15:0] mem [32] = '{3: 16'h1234, default: 16'h0000};
    logic [15:0] ref_mem [32] = '{3: 16'h1234, default: 16'h0000};

    // Register-file responder: read data appears the cycle after reg_re.
    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            mon_addr  = reg_addr;
            mon_wdata = reg_wdata;
            mem[reg_addr] = reg_wdata;
        end
        if (reg_re) begin
            re_cnt++;
            reg_rdata = mem[reg_addr];
        end
        if (frame_err) err_cnt++;
        if (reg_we && reg_re) overlap_cnt++;
    end

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [15:0] wdata;
        int          nbits;
        int          exp_we;
        int          exp_re;
        int          exp_err;
        logic        chk_rx;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [15:0] wtail(input int n);
        wtail = STATUS_ON ? {8'hA5, 8'(n)} : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_bit(input logic b, output logic sampled);
        spi_mosi = b;
        wait_clks(HALF);
        spi_sck = 1'b1;
        sampled = spi_miso;
        wait_clks(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic spi_frame(input logic [TX-1:0] cmd, input int nbits, input int gap,
                             output logic [RX-1:0] rx);
        logic s;
        rx = '0;
        spi_csn = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            sck_bit((i < TX) ? cmd[TX-1-i] : 1'b0, s);
            if (i >= TX) rx = {rx[RX-2:0], s};
        end
        wait_clks(HALF);
        spi_csn = 1'b1;
        wait_clks(gap);
    endtask

    task automatic run_frame(input string tag, input logic rw, input logic [4:0] addr,
                             input logic [15:0] wdata, input int nbits, input int exp_we,
                             input int exp_re, input int exp_err, input logic chk_rx,
                             input logic [15:0] exp_rx);
        int we0, re0, err0;
        logic [15:0] rx;
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt;
        spi_frame({rw, addr, wdata}, nbits, 8, rx);
        chk({tag, "_we"}, we_cnt - we0, exp_we);
        chk({tag, "_re"}, re_cnt - re0, exp_re);
        chk({tag, "_err"}, err_cnt - err0, exp_err);
        chk({tag, "_oe"}, spi_miso_oe, 0);
        if (exp_we != 0) begin
            chk({tag, "_addr"}, mon_addr, addr);
            chk({tag, "_wdata"}, mon_wdata, wdata);
        end
        if (chk_rx) chk({tag, "_rx"}, rx, exp_rx);
        if (nbits == DW) fc_model++;
        if (rw && nbits == DW) ref_mem[addr] = wdata;
    endtask

    initial begin
        logic [15:0] rx1, rx2, exp_rx;
        logic        s, rw;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [21:0] cmd;
        int          nb, we0, re0, err0;

        vecs[0]  = '{1'b1, 5'h0A, 16'hBEEF, 38, 1, 0, 0, 1'b1, wtail(0)};
        vecs[1]  = '{1'b0, 5'h03, 16'h0000, 38, 0, 1, 0, 1'b1, 16'h1234};
        vecs[2]  = '{1'b1, 5'h0A, 16'h1111, 30, 0, 0, 1, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 5'h0A, 16'h0000, 38, 0, 1, 0, 1'b1, 16'hBEEF};
        vecs[4]  = '{1'b0, 5'h03, 16'h0000, 25, 0, 1, 1, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 5'h1F, 16'hFFFF, 38, 1, 0, 0, 1'b1, wtail(3)};
        vecs[6]  = '{1'b0, 5'h1F, 16'h0000, 38, 0, 1, 0, 1'b1, 16'hFFFF};
        vecs[7]  = '{1'b1, 5'h00, 16'hABCD, 39, 0, 0, 1, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 5'h05, 16'h4444, 0,  0, 0, 0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 5'h00, 16'h0000, 38, 0, 1, 0, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 5'h10, 16'h8001, 38, 1, 0, 0, 1'b1, wtail(6)};
        vecs[11] = '{1'b0, 5'h10, 16'h0000, 38, 0, 1, 0, 1'b1, 16'h8001};
        vecs[12] = '{1'b1, 5'h02, 16'h7777, 22, 0, 0, 1, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 5'h02, 16'h0000, 38, 0, 1, 0, 1'b1, 16'h0000};

        wait_clks(1);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_miso", spi_miso, 0);
        chk("rst_strobes", {reg_we, reg_re, frame_err}, 0);
        chk("rst_addr_wdata", {reg_addr, reg_wdata}, 0);
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(10);

        for (int i = 0; i < 14; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                      vecs[i].nbits, vecs[i].exp_we, vecs[i].exp_re, vecs[i].exp_err,
                      vecs[i].chk_rx, vecs[i].exp_rx);
        end

        // Back-to-back: CSN high for only 2 clk between a write and a read of the same register.
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt;
        spi_frame({1'b1, 5'h01, 16'h5555}, DW, 2, rx1);
        spi_frame({1'b0, 5'h01, 16'h0000}, DW, 8, rx2);
        chk("b2b_write_tail", rx1, wtail(fc_model));
        chk("b2b_we", we_cnt - we0, 1);
        chk("b2b_addr", mon_addr, 5'h01);
        chk("b2b_wdata", mon_wdata, 16'h5555);
        chk("b2b_re", re_cnt - re0, 1);
        chk("b2b_err", err_cnt - err0, 0);
        chk("b2b_rx", rx2, 16'h5555);
        fc_model += 2;
        ref_mem[1] = 16'h5555;

        for (int i = 0; i < 40; i++) begin
            rw    = 1'($urandom_range(0, 1));
            addr  = 5'($urandom_range(0, 7));
            wdata = 16'($urandom);
            nb    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 37)) : DW;
            exp_rx = rw ? wtail(fc_model) : ref_mem[addr];
            run_frame($sformatf("rnd%0d", i), rw, addr, wdata, nb,
                      (rw && nb == DW) ? 1 : 0, (!rw && nb >= TX) ? 1 : 0,
                      (nb != DW) ? 1 : 0, nb == DW, exp_rx);
        end

        // Asynchronous reset 10 bits into a write frame; the remainder must be ignored.
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt;
        cmd = {1'b1, 5'h01, 16'h9999};
        spi_csn = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 10; i++) sck_bit(cmd[TX-1-i], s);
        chk("mid_oe", spi_miso_oe, 1);
        rst_n = 1'b0;
        wait_clks(2);
        chk("mrst_oe", spi_miso_oe, 0);
        chk("mrst_miso", spi_miso, 0);
        chk("mrst_strobes", {reg_we, reg_re, frame_err}, 0);
        chk("mrst_addr_wdata", {reg_addr, reg_wdata}, 0);
        rst_n = 1'b1;
        fc_model = 0;
        for (int i = 10; i < DW; i++) sck_bit((i < TX) ? cmd[TX-1-i] : 1'b0, s);
        wait_clks(HALF);
        spi_csn = 1'b1;
        wait_clks(8);
        chk("mrst_we", we_cnt - we0, 0);
        chk("mrst_re", re_cnt - re0, 0);
        chk("mrst_err", err_cnt - err0, 0);
        run_frame("post_rst_read", 1'b0, 5'h01, 16'h0000, DW, 0, 1, 0, 1'b1, ref_mem[1]);
        run_frame("post_rst_write", 1'b1, 5'h06, 16'h0F0F, DW, 1, 0, 0, 1'b1, wtail(fc_model));

        chk("we_re_overlap", overlap_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
